// File: rtl/port_activity_led.sv
// port_activity_led: per-port link/activity LED driver for the 4x RGMII NIC,
// with heartbeat, lamp-test and blank modes for board bring-up.
module port_activity_led #(
    parameter int NUM_PORTS = 4,
    parameter int TICK_DIV  = 125000,
    parameter int BLINK_MS  = 40,
    parameter int HB_MS     = 500
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] link_up,
    input  logic [NUM_PORTS-1:0] act_rx,
    input  logic [NUM_PORTS-1:0] act_tx,
    input  logic [1:0]           mode,
    output logic [NUM_PORTS-1:0] led_out,
    output logic                 tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = ($clog2(BLINK_MS) > 8) ? $clog2(BLINK_MS) : 8;
    localparam int HW = (HB_MS > 1) ? $clog2(HB_MS) : 1;

    localparam logic [CW-1:0] PRE_LAST = CW'(TICK_DIV - 1);
    localparam logic [TW-1:0] BLK_LOAD = TW'(BLINK_MS - 1);
    localparam logic [HW-1:0] HB_LAST  = HW'(HB_MS - 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_LINK,
        S_BLK_OFF,
        S_BLK_ON
    } state_e;

    logic [CW-1:0]        pre_q, pre_d;
    logic [HW-1:0]        hb_cnt_q, hb_cnt_d;
    logic                 hb_q, hb_d;
    logic [NUM_PORTS-1:0] pend_q, pend_d;
    logic [NUM_PORTS-1:0] consume;
    logic [NUM_PORTS-1:0] port_led;
    logic [NUM_PORTS-1:0] led_q, led_d;
    state_e               state_q [NUM_PORTS];
    state_e               state_d [NUM_PORTS];
    logic [TW-1:0]        timer_q [NUM_PORTS];
    logic [TW-1:0]        timer_d [NUM_PORTS];

    assign tick    = (pre_q == PRE_LAST);
    assign led_out = led_q;

    always_comb begin
        pre_d    = tick ? '0 : pre_q + 1'b1;
        hb_cnt_d = hb_cnt_q;
        hb_d     = hb_q;
        if (tick) begin
            if (hb_cnt_q == HB_LAST) begin
                hb_cnt_d = '0;
                hb_d     = ~hb_q;
            end else begin
                hb_cnt_d = hb_cnt_q + 1'b1;
            end
        end
    end

    // A new strobe in the consume cycle keeps pend set.
    assign pend_d = link_up & ((act_rx | act_tx) | (pend_q & ~consume));

    always_comb begin
        consume = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            state_d[p] = state_q[p];
            timer_d[p] = timer_q[p];
            if (!link_up[p]) begin
                state_d[p] = S_OFF;
                timer_d[p] = '0;
            end else begin
                unique case (state_q[p])
                    S_OFF: state_d[p] = S_LINK;
                    S_LINK: begin
                        if (pend_q[p]) begin
                            state_d[p] = S_BLK_OFF;
                            timer_d[p] = BLK_LOAD;
                            consume[p] = 1'b1;
                        end
                    end
                    S_BLK_OFF: begin
                        if (tick) begin
                            if (timer_q[p] != '0) begin
                                timer_d[p] = timer_q[p] - 1'b1;
                            end else begin
                                state_d[p] = S_BLK_ON;
                                timer_d[p] = BLK_LOAD;
                            end
                        end
                    end
                    S_BLK_ON: begin
                        if (tick) begin
                            if (timer_q[p] != '0) begin
                                timer_d[p] = timer_q[p] - 1'b1;
                            end else if (pend_q[p]) begin
                                state_d[p] = S_BLK_OFF;
                                timer_d[p] = BLK_LOAD;
                                consume[p] = 1'b1;
                            end else begin
                                state_d[p] = S_LINK;
                            end
                        end
                    end
                    default: state_d[p] = S_OFF;
                endcase
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_led[p] = (state_q[p] == S_LINK) ||
                          (state_q[p] == S_BLK_ON);
        end
    end

    always_comb begin
        led_d = '0;
        unique case (mode)
            2'd0:    led_d = port_led;
            2'd1:    led_d = {NUM_PORTS{hb_q}};
            2'd2:    led_d = '1;
            default: led_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q    <= '0;
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
            pend_q   <= '0;
            led_q    <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                state_q[p] <= S_OFF;
                timer_q[p] <= '0;
            end
        end else begin
            pre_q    <= pre_d;
            hb_cnt_q <= hb_cnt_d;
            hb_q     <= hb_d;
            pend_q   <= pend_d;
            led_q    <= led_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                state_q[p] <= state_d[p];
                timer_q[p] <= timer_d[p];
            end
        end
    end

endmodule

// File: tb/tb_port_activity_led.sv
// tb_port_activity_led: directed bench for port_activity_led with a
// queue of expected LED vectors and scalar timing checks.
module tb_port_activity_led;
    localparam int NP = 4;
    localparam int TD = 10;
    localparam int BM = 3;
    localparam int HM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NP-1:0] link_up;
    logic [NP-1:0] act_rx;
    logic [NP-1:0] act_tx;
    logic [1:0]    mode;
    logic [NP-1:0] led_out;
    logic          tick;

    int vectors     = 0;
    int miscompares = 0;
    int pc          = 0;

    typedef struct {
        string         tag;
        logic [NP-1:0] exp;
    } exp_t;

    exp_t sb[$];

    port_activity_led #(
        .NUM_PORTS(NP),
        .TICK_DIV (TD),
        .BLINK_MS (BM),
        .HB_MS    (HM)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .link_up(link_up),
        .act_rx (act_rx),
        .act_tx (act_tx),
        .mode   (mode),
        .led_out(led_out),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; the prescaler must track it mod TD.
    always @(posedge clk) pc <= reset ? 0 : pc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: sim time expired, vectors=%0d", vectors);
        $fatal(1);
    end

    task automatic push(input string tag, input logic [NP-1:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic pop_check();
        exp_t x;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty: led_out=%b expected queued entry",
                   led_out);
        end else begin
            x = sb.pop_front();
            assert (led_out === x.exp) else begin
                miscompares++;
                $error("FAIL %s: led_out=%b expected %b",
                       x.tag, led_out, x.exp);
            end
        end
    endtask

    task automatic check_int(input string tag, input int obs,
                             input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs,
                             input int lo, input int hi);
        vectors++;
        assert (obs >= lo && obs <= hi) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d..%0d",
                   tag, obs, lo, hi);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_len(input int idx, input logic lvl,
                           input int max, output int n);
        n = 0;
        while (n < max && led_out[idx] === lvl) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_tick(input int max, output int n);
        n = 0;
        while (n < max && tick !== 1'b1) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int first;
        reset   = 1'b1;
        link_up = '0;
        act_rx  = '0;
        act_tx  = '0;
        mode    = 2'd0;
        cyc(3);

        // 1: reset state, timebase, link latency
        push("rst_led", 4'b0000);
        pop_check();
        check_int("rst_tick", tick, 0);
        reset = 1'b0;
        wait_tick(50, n);
        check_int("first_tick", n, TD - 1);
        cyc(1);
        check_int("tick_width", tick, 0);
        wait_tick(50, n);
        check_int("tick_period", n + 1, TD);
        push("idle_led", 4'b0000);
        pop_check();
        link_up = 4'b0101;
        push("link_lat1", 4'b0000);
        push("link_lat2", 4'b0101);
        cyc(1);
        pop_check();
        cyc(1);
        pop_check();
        cyc(5);

        // 2: single act_rx pulse on port0
        act_rx = 4'b0001;
        cyc(1);
        act_rx = '0;
        run_len(0, 1'b1, 20, n);
        check_int("blk_delay", n, 2);
        push("blk_off_led", 4'b0100);
        pop_check();
        run_len(0, 1'b0, 50, n);
        check_rng("blk_off_len", n, (BM - 1) * TD + 1, BM * TD);
        push("blk_on_led", 4'b0101);
        pop_check();
        run_len(0, 1'b1, 100, n);
        check_int("blk_on_then_link", n, 100);

        // 3: act_tx[2] held, then dropped at start of an on phase
        act_tx = 4'b0100;
        run_len(2, 1'b1, 20, n);
        check_int("sq_delay", n, 3);
        run_len(2, 1'b0, 50, n);
        check_rng("sq_off1", n, (BM - 1) * TD + 1, BM * TD);
        run_len(2, 1'b1, 50, n);
        check_int("sq_on1", n, BM * TD);
        run_len(2, 1'b0, 50, n);
        check_int("sq_off2", n, BM * TD);
        act_tx = '0;
        run_len(2, 1'b1, 50, n);
        check_int("sq_on2", n, BM * TD);
        run_len(2, 1'b0, 50, n);
        check_int("sq_off3", n, BM * TD);
        run_len(2, 1'b1, 100, n);
        check_int("sq_solid", n, 100);
        push("sq_end", 4'b0101);
        pop_check();

        // 4: link drop in BLK_ON with pend set
        act_rx = 4'b0001;
        cyc(1);
        act_rx = '0;
        run_len(0, 1'b1, 20, n);
        check_int("t4_delay", n, 2);
        run_len(0, 1'b0, 50, n);
        check_rng("t4_off", n, (BM - 1) * TD + 1, BM * TD);
        act_rx = 4'b0001;
        cyc(1);
        act_rx  = '0;
        link_up = 4'b0100;
        push("drop1", 4'b0101);
        push("drop2", 4'b0100);
        cyc(1);
        pop_check();
        cyc(1);
        pop_check();
        cyc(5);
        link_up = 4'b0101;
        push("relink1", 4'b0100);
        push("relink2", 4'b0101);
        cyc(1);
        pop_check();
        cyc(1);
        pop_check();
        run_len(0, 1'b1, 100, n);
        check_int("no_stale", n, 100);

        // 5: heartbeat, lamp test, blank, back to activity
        link_up = '0;
        cyc(3);
        push("unlinked", 4'b0000);
        pop_check();
        mode = 2'd1;
        for (int i = 0; i < 16; i++) begin
            cyc(5);
            push("hb", (((pc - 1) / (HM * TD)) % 2 == 1) ? 4'hF : 4'h0);
            pop_check();
        end
        mode = 2'd2;
        push("lamp", 4'b1111);
        cyc(1);
        pop_check();
        mode = 2'd3;
        push("blank", 4'b0000);
        cyc(1);
        pop_check();
        link_up = 4'b0011;
        cyc(5);
        push("blank_hold", 4'b0000);
        pop_check();
        mode = 2'd0;
        push("live_fsm", 4'b0011);
        cyc(1);
        pop_check();

        // 6: reset mid-blink with a strobe in the reset cycle
        act_rx = 4'b0001;
        cyc(1);
        act_rx = '0;
        run_len(0, 1'b1, 20, n);
        check_int("t6_delay", n, 2);
        cyc(5);
        reset  = 1'b1;
        act_rx = 4'b0001;
        cyc(1);
        act_rx = '0;
        reset  = 1'b0;
        push("rst_mid", 4'b0000);
        pop_check();
        check_int("rst_mid_tick", tick, 0);
        first = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) begin
                push("rst_relink1", 4'b0000);
                pop_check();
            end
            if (i == 2) begin
                push("rst_relink2", 4'b0011);
                pop_check();
            end
            if (tick === 1'b1 && first < 0) first = i;
        end
        check_int("rst_first_tick", first, TD - 1);
        run_len(0, 1'b1, 100, n);
        check_int("rst_no_stale", n, 100);
        push("final", 4'b0011);
        pop_check();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
